reg_bcd_display: RTL and testbench

- Downstream consumer of the CPU's register-5 debug value (lower 16 bits).
- Converts the binary value to 4 decimal digits using a sequential double-dabble engine.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the register file debug tap and the board's segment/anode pins, as a decimal alternative to the hex display path.

---
 rtl/reg_bcd_display.sv | 162 ++++++++++++++++
 tb/tb_reg_bcd_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : reg_bcd_display
// Description : Shows the low 16 bits of the register-5 debug value as four
//               decimal digits on a multiplexed common-anode 7-segment display.
//               A sequential double-dabble engine (16 cycles per value) does
//               the binary-to-BCD conversion. A free-running scan counter
//               walks the four digits.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset
//               data_i   - binary value to display
//               segments - active-low segments, [0]=a .. [6]=g, [7]=dp
//               an       - active-low anode select, an[0] = rightmost digit
//               busy     - conversion in progress
//               overflow - committed value is greater than 9999
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bcd_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    output logic [7:0]  segments,
    output logic [3:0]  an,
    output logic        busy,
    output logic        overflow
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_last_val;
    logic [35:0] r_shift;      // {5 BCD nibbles, 16-bit binary}
    logic [3:0]  r_iter;
    logic [15:0] r_bcd_q;
    logic        r_overflow;
    logic        r_busy;

    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_digit_idx;
    logic [3:0]       r_an;
    logic [7:0]       r_segments;

    logic [19:0] w_bcd_adj;
    logic [35:0] w_next;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [7:0]  w_seg;

    // Double-dabble: correct every BCD nibble that would exceed 9 after the shift.
    for (genvar n = 0; n < 5; n++) begin : g_adj
        logic [3:0] w_nib;
        assign w_nib = r_shift[16 + 4*n +: 4];
        assign w_bcd_adj[4*n +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    assign w_next = {w_bcd_adj, r_shift[15:0]} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_val <= 16'd0;
            r_shift    <= 36'd0;
            r_iter     <= 4'd0;
            r_bcd_q    <= 16'd0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (data_i != r_last_val) begin
                        r_last_val <= data_i;
                        r_shift    <= {20'd0, data_i};
                        r_iter     <= 4'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_next;
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_bcd_q    <= w_next[31:16];
                        r_overflow <= |w_next[35:32];
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Digit currently selected by the scan, and whether it is a leading zero.
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (r_digit_idx)
            2'd0: begin w_digit = r_bcd_q[3:0];   w_blank = 1'b0;                end
            2'd1: begin w_digit = r_bcd_q[7:4];   w_blank = (r_bcd_q[15:4] == 12'd0); end
            2'd2: begin w_digit = r_bcd_q[11:8];  w_blank = (r_bcd_q[15:8] == 8'd0);  end
            default: begin w_digit = r_bcd_q[15:12]; w_blank = (r_bcd_q[15:12] == 4'd0); end
        endcase
    end

    always_comb begin
        w_seg = 8'hFF;
        if (r_overflow) begin
            w_seg = 8'b1011_1111;
        end else if ((BLANK_LZ != 0) && w_blank) begin
            w_seg = 8'hFF;
        end else begin
            case (w_digit)
                4'd0: w_seg = 8'b1100_0000;
                4'd1: w_seg = 8'b1111_1001;
                4'd2: w_seg = 8'b1010_0100;
                4'd3: w_seg = 8'b1011_0000;
                4'd4: w_seg = 8'b1001_1001;
                4'd5: w_seg = 8'b1001_0010;
                4'd6: w_seg = 8'b1000_0010;
                4'd7: w_seg = 8'b1111_1000;
                4'd8: w_seg = 8'b1000_0000;
                4'd9: w_seg = 8'b1001_0000;
                default: w_seg = 8'hFF;
            endcase
        end
    end

    // Scan runs independently of the converter; an and segments share one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_digit_idx <= 2'd0;
            r_an        <= 4'b1111;
            r_segments  <= 8'hFF;
        end else begin
            if (r_div_cnt == c_DIV_LAST) begin
                r_div_cnt   <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            r_an       <= ~(4'b0001 << r_digit_idx);
            r_segments <= w_seg;
        end
    end

    assign segments = r_segments;
    assign an       = r_an;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_reg_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bcd_display
// Description : Self-checking bench for reg_bcd_display. Stimulus pushes the
//               value each conversion should commit; a negedge monitor pops it
//               when busy falls and checks every displayed digit against a
//               decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_i = 16'd0;
    logic [7:0]  segments;
    logic [3:0]  an;
    logic        busy;
    logic        overflow;

    reg_bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .segments (segments),
        .an       (an),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned exp_q[$];
    int unsigned m_last = 0;
    bit rst_q = 1'b0;

    always @(posedge clk) rst_q = rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] seg7(input int unsigned d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    // Expected pattern for digit position k of a value, from decimal arithmetic.
    function automatic logic [7:0] model_seg(input int unsigned val, input int k);
        int unsigned p;
        p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        if (val > 9999) return 8'hBF;
        if (k > 0 && val < p) return 8'hFF;
        return seg7((val / p) % 10);
    endfunction

    // ---------------- monitor ----------------
    int unsigned shown_val = 0;
    int unsigned popped;
    bit          prev_busy = 1'b0;
    int          bcount = 0;
    logic [3:0]  prev_an = 4'hF;
    int          slot_len = 0;
    bit          skip_seg;
    int          idx;

    always @(negedge clk) begin
        if (rst_q) begin
            check("rst_segments", {24'd0, segments}, 32'hFF);
            check("rst_an", {28'd0, an}, 32'hF);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_overflow", {31'd0, overflow}, 32'd0);
            shown_val = 0;
            prev_busy = 1'b0;
            bcount    = 0;
            prev_an   = 4'hF;
            slot_len  = 0;
        end else begin
            skip_seg = 1'b0;
            if (busy) bcount++;
            if (prev_busy && !busy) begin
                check("busy_len", bcount, 16);
                bcount = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got commit expected none at %0t", $time);
                end else begin
                    popped = exp_q.pop_front();
                    check("overflow", {31'd0, overflow}, {31'd0, popped > 9999});
                    shown_val = popped;
                    skip_seg  = 1'b1;   // segments still carry the old value this cycle
                end
            end
            prev_busy = busy;

            if (an != prev_an) begin
                if (prev_an != 4'hF) begin
                    check("slot_len", slot_len, 4);
                    check("scan_order", {28'd0, an}, {28'd0, prev_an[2:0], prev_an[3]});
                end
                slot_len = 1;
                prev_an  = an;
            end else begin
                slot_len++;
            end

            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL an_onehot: got %b expected one low bit at %0t", an, $time);
            end else if (!skip_seg) begin
                check("segments", {24'd0, segments}, {24'd0, model_seg(shown_val, idx)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input int unsigned v);
        data_i = v[15:0];
        if (v != m_last) begin
            exp_q.push_back(v);
            m_last = v;
        end
    endtask

    task automatic do_reset(input int n, input int unsigned v);
        rst    = 1'b1;
        data_i = v[15:0];
        exp_q.delete();
        tick(n);
        rst    = 1'b0;
        m_last = 0;
        issue(v);
    endtask

    // Wait for all expected commits, then let the scan sweep all digits.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        tick(20);
    endtask

    initial begin
        int unsigned v;
        int unsigned v2;
        tick(1);
        do_reset(3, 1234);
        drain();

        issue(7);      drain();
        issue(10000);  drain();
        issue(9999);   drain();

        issue(42);  tick(5);  issue(815);  drain();

        // Reset in the middle of a conversion; a different value follows it.
        issue(3333);  tick(9);
        do_reset(2, 2468);
        drain();

        do_reset(3, 0);  drain();
        issue(65535);    drain();

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 9);
                1: v = $urandom_range(0, 999);
                2: v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, 65535);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                issue(v);
                tick($urandom_range(1, 12));
                v2 = $urandom_range(0, 12000);
                issue(v2);
            end else begin
                issue(v);
            end
            drain();
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
